// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between an instruction-fetch requester and a
// data load/store requester, with starvation protection and an access timeout.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic [31:0] i_data,
    output logic        i_valid,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_storeData,
    input  logic [3:0]  d_byteEnable,
    output logic [31:0] d_loadData,
    output logic        d_done,
    output logic        d_error,
    output logic [31:0] m_address,
    output logic [31:0] m_storeData,
    output logic [3:0]  m_byteEnable,
    output logic        m_storeValid,
    input  logic [31:0] m_loadData,
    input  logic        m_loadDataValid,
    input  logic        m_storeComplete,
    output logic        busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, GAP} state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          misalign_q;
    logic          d_go;
    logic          i_go;
    logic          tmo_hit;

    // A requester whose completion pulse is high this cycle is not re-granted yet.
    assign d_go    = d_req && !d_done && ((starve_cnt < SW'(STARVE_LIMIT)) || !i_req);
    assign i_go    = i_req && !i_valid;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            tmo_cnt      <= '0;
            misalign_q   <= 1'b0;
            i_data       <= '0;
            i_valid      <= 1'b0;
            d_loadData   <= '0;
            d_done       <= 1'b0;
            d_error      <= 1'b0;
            m_address    <= '0;
            m_storeData  <= '0;
            m_byteEnable <= '0;
            m_storeValid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_done  <= 1'b0;
            d_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_go) begin
                        if (!i_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        tmo_cnt   <= '0;
                        busy      <= 1'b1;
                        m_address <= d_address;
                        if (d_write) begin
                            state        <= STORE;
                            m_storeData  <= d_storeData;
                            m_byteEnable <= d_byteEnable;
                            m_storeValid <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (i_go) begin
                        starve_cnt <= '0;
                        tmo_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= FETCH;
                        misalign_q <= |i_address[1:0];
                        // A misaligned fetch never reaches memory; it completes as a NOP.
                        m_address  <= (|i_address[1:0]) ? '0 : i_address;
                    end
                end
                FETCH: begin
                    if (misalign_q || (tmo_hit && !m_loadDataValid)) begin
                        i_data    <= NOP;
                        i_valid   <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        m_address <= '0;
                    end else if (m_loadDataValid) begin
                        i_data    <= m_loadData;
                        i_valid   <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        m_address <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (m_loadDataValid || tmo_hit) begin
                        d_loadData <= m_loadDataValid ? m_loadData : '0;
                        d_done     <= 1'b1;
                        d_error    <= !m_loadDataValid;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        m_address  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                STORE: begin
                    if (m_storeComplete || tmo_hit) begin
                        if (!m_storeComplete) begin
                            d_loadData <= '0;
                        end
                        d_done       <= 1'b1;
                        d_error      <= !m_storeComplete;
                        state        <= GAP;
                        m_storeValid <= 1'b0;
                        m_address    <= '0;
                        m_storeData  <= '0;
                        m_byteEnable <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, load, store, starvation order,
// timeouts, misaligned fetch and reset in the middle of a store.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_address;
    logic [31:0] i_data;
    logic        i_valid;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_storeData;
    logic [3:0]  d_byteEnable;
    logic [31:0] d_loadData;
    logic        d_done;
    logic        d_error;
    logic [31:0] m_address;
    logic [31:0] m_storeData;
    logic [3:0]  m_byteEnable;
    logic        m_storeValid;
    logic [31:0] m_loadData;
    logic        m_loadDataValid;
    logic        m_storeComplete;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_data(i_data), .i_valid(i_valid),
        .d_req(d_req), .d_write(d_write), .d_address(d_address),
        .d_storeData(d_storeData), .d_byteEnable(d_byteEnable),
        .d_loadData(d_loadData), .d_done(d_done), .d_error(d_error),
        .m_address(m_address), .m_storeData(m_storeData), .m_byteEnable(m_byteEnable),
        .m_storeValid(m_storeValid), .m_loadData(m_loadData),
        .m_loadDataValid(m_loadDataValid), .m_storeComplete(m_storeComplete),
        .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0] grants [10];
    string      exp_order;
    logic       prev_busy;
    int         g;
    int         cyc;

    initial begin
        reset = 1'b1; i_req = 1'b0; i_address = '0; d_req = 1'b0; d_write = 1'b0;
        d_address = '0; d_storeData = '0; d_byteEnable = '0; m_loadData = '0;
        m_loadDataValid = 1'b0; m_storeComplete = 1'b0;
        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_i_valid", {31'b0, i_valid}, 32'd0);
        chk("rst_d_done", {31'b0, d_done}, 32'd0);
        chk("rst_m_storeValid", {31'b0, m_storeValid}, 32'd0);
        chk("rst_m_address", m_address, 32'd0);
        chk("rst_i_data", i_data, 32'd0);
        reset = 1'b0;

        // Aligned fetch
        i_req = 1'b1; i_address = 32'h100;
        tick();
        chk("fetch_busy", {31'b0, busy}, 32'd1);
        chk("fetch_m_address", m_address, 32'h100);
        chk("fetch_storeValid", {31'b0, m_storeValid}, 32'd0);
        chk("fetch_no_early_valid", {31'b0, i_valid}, 32'd0);
        m_loadData = 32'hDEADBEEF; m_loadDataValid = 1'b1;
        tick();
        chk("fetch_i_valid", {31'b0, i_valid}, 32'd1);
        chk("fetch_i_data", i_data, 32'hDEADBEEF);
        i_req = 1'b0; m_loadDataValid = 1'b0;
        tick();
        chk("fetch_pulse_end", {31'b0, i_valid}, 32'd0);
        chk("fetch_i_data_hold", i_data, 32'hDEADBEEF);
        chk("idle_m_address", m_address, 32'd0);

        // Store with completion one cycle after m_storeValid rises
        d_req = 1'b1; d_write = 1'b1; d_address = 32'h40; d_storeData = 32'h11223344;
        d_byteEnable = 4'b0011;
        tick();
        chk("store_valid", {31'b0, m_storeValid}, 32'd1);
        chk("store_addr", m_address, 32'h40);
        chk("store_data", m_storeData, 32'h11223344);
        chk("store_be", {28'b0, m_byteEnable}, 32'h3);
        tick();
        chk("store_hold", {31'b0, m_storeValid}, 32'd1);
        chk("store_no_done", {31'b0, d_done}, 32'd0);
        m_storeComplete = 1'b1;
        tick();
        chk("store_done", {31'b0, d_done}, 32'd1);
        chk("store_error", {31'b0, d_error}, 32'd0);
        chk("gap_storeValid", {31'b0, m_storeValid}, 32'd0);
        chk("gap_busy", {31'b0, busy}, 32'd1);
        d_req = 1'b0; m_storeComplete = 1'b0;
        tick();
        chk("after_gap_busy", {31'b0, busy}, 32'd0);
        chk("after_gap_done", {31'b0, d_done}, 32'd0);

        // Load with one wait cycle
        d_req = 1'b1; d_write = 1'b0; d_address = 32'h80;
        tick();
        chk("load_busy", {31'b0, busy}, 32'd1);
        chk("load_addr", m_address, 32'h80);
        tick();
        chk("load_wait", {31'b0, d_done}, 32'd0);
        m_loadData = 32'hCAFEF00D; m_loadDataValid = 1'b1;
        tick();
        chk("load_done", {31'b0, d_done}, 32'd1);
        chk("load_data", d_loadData, 32'hCAFEF00D);
        chk("load_error", {31'b0, d_error}, 32'd0);
        d_req = 1'b0; m_loadDataValid = 1'b0;
        tick();

        // Both requesters held high: starvation limit interleaves a fetch
        i_req = 1'b1; i_address = 32'h400; d_req = 1'b1; d_write = 1'b1;
        d_address = 32'h500; d_storeData = 32'hA5A5A5A5; d_byteEnable = 4'hF;
        m_storeComplete = 1'b1; m_loadDataValid = 1'b1; m_loadData = 32'h55AA55AA;
        prev_busy = busy;
        g = 0;
        for (int n = 0; n < 80 && g < 10; n++) begin
            tick();
            if (busy && !prev_busy) begin
                grants[g] = m_storeValid ? "D" : "I";
                g++;
            end
            prev_busy = busy;
        end
        i_req = 1'b0; d_req = 1'b0; m_storeComplete = 1'b0;
        exp_order = "DDDDIDDDDI";
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("grant%0d", k), {24'b0, grants[k]}, {24'b0, exp_order[k]});
        end
        tick();
        m_loadDataValid = 1'b0;
        tick();
        chk("starve_idle", {31'b0, busy}, 32'd0);

        // Fetch with no memory response times out with a NOP
        i_req = 1'b1; i_address = 32'h300;
        tick();
        cyc = 0;
        for (int n = 0; n < 40 && !i_valid; n++) begin
            if (busy) cyc++;
            tick();
        end
        chk("ftmo_valid", {31'b0, i_valid}, 32'd1);
        chk("ftmo_cycles", cyc, 32'd16);
        chk("ftmo_data", i_data, 32'h13);
        i_req = 1'b0;
        tick();

        // Store with byteEnable 0000 and no completion aborts through GAP
        d_req = 1'b1; d_write = 1'b1; d_address = 32'h200; d_storeData = 32'h99;
        d_byteEnable = 4'b0000;
        tick();
        chk("be0_storeValid", {31'b0, m_storeValid}, 32'd1);
        chk("be0_be", {28'b0, m_byteEnable}, 32'd0);
        cyc = 0;
        for (int n = 0; n < 40 && !d_done; n++) begin
            if (m_storeValid) cyc++;
            tick();
        end
        chk("stmo_done", {31'b0, d_done}, 32'd1);
        chk("stmo_error", {31'b0, d_error}, 32'd1);
        chk("stmo_cycles", cyc, 32'd16);
        chk("stmo_loadData", d_loadData, 32'd0);
        chk("stmo_gap_busy", {31'b0, busy}, 32'd1);
        d_req = 1'b0;
        tick();
        chk("stmo_idle", {31'b0, busy}, 32'd0);
        chk("stmo_err_pulse", {31'b0, d_error}, 32'd0);

        // Reset in the second STORE cycle
        d_req = 1'b1; d_address = 32'h600; d_storeData = 32'h1; d_byteEnable = 4'hF;
        tick();
        tick();
        chk("rstmid_store2", {31'b0, m_storeValid}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rstmid_storeValid", {31'b0, m_storeValid}, 32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_done", {31'b0, d_done}, 32'd0);
        chk("rstmid_i_data", i_data, 32'd0);
        reset = 1'b0; d_req = 1'b0;
        i_req = 1'b1; i_address = 32'h104; m_loadData = 32'h12345678; m_loadDataValid = 1'b1;
        tick();
        chk("postrst_busy", {31'b0, busy}, 32'd1);
        chk("postrst_addr", m_address, 32'h104);
        chk("postrst_no_done", {31'b0, d_done}, 32'd0);
        tick();
        chk("postrst_valid", {31'b0, i_valid}, 32'd1);
        chk("postrst_data", i_data, 32'h12345678);
        i_req = 1'b0;
        tick();

        // Misaligned fetch returns a NOP without touching memory
        i_req = 1'b1; i_address = 32'h102; m_loadData = 32'h77777777;
        tick();
        chk("mis_busy", {31'b0, busy}, 32'd1);
        chk("mis_m_address", m_address, 32'd0);
        tick();
        chk("mis_valid", {31'b0, i_valid}, 32'd1);
        chk("mis_data", i_data, 32'h13);
        i_req = 1'b0; m_loadDataValid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
